// File: rtl/accumulator_bank_if.sv
// accumulator_bank_if: input beat, drain request and output stream signals of the accumulator bank
interface accumulator_bank_if #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic in_valid;
  logic in_ready;
  logic [ARR_SIZE*DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic in_mode;
  logic drain_start;
  logic [ADDR_W-1:0] drain_base;
  logic [ADDR_W:0] drain_len;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic busy;
  logic sat_flag;
  modport slave (
    input in_valid, in_data, in_addr, in_mode, drain_start, drain_base, drain_len, out_ready,
    output in_ready, out_valid, out_data, out_addr, busy, sat_flag
  );
  modport master (
    output in_valid, in_data, in_addr, in_mode, drain_start, drain_base, drain_len, out_ready,
    input in_ready, out_valid, out_data, out_addr, busy, sat_flag
  );
endinterface

// File: rtl/accumulator_bank.sv
// accumulator_bank: saturating per-entry accumulation of lane sums with a clear-on-read drain stream
module accumulator_bank #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst,
  accumulator_bank_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SUM_W = DATA_W + $clog2(ARR_SIZE);
  localparam int FULL_W = SUM_W + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state_q, state_d;
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] mem_d [DEPTH];
  logic s1_valid_q, s1_valid_d;
  logic s1_mode_q, s1_mode_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic sat_q, sat_d;
  logic hs, last, ovf;
  logic signed [FULL_W-1:0] full;
  logic [DATA_W-1:0] wr_val;
  logic [ADDR_W-1:0] ptr_nx;
  always_comb begin
    s1_valid_d = bus.in_valid & bus.in_ready;
    s1_mode_d = bus.in_mode;
    s1_addr_d = bus.in_addr;
    s1_sum_d = '0;
    for (int k = 0; k < ARR_SIZE; k++)
      s1_sum_d = s1_sum_d + SUM_W'($signed(bus.in_data[k*DATA_W +: DATA_W]));
  end
  // reading mem_q here sees the previous beat's write, so same-address beats chain without a stall
  always_comb begin
    full = s1_mode_q ? FULL_W'(s1_sum_q) : FULL_W'(mem_q[s1_addr_q]) + FULL_W'(s1_sum_q);
    ovf = ~(&full[FULL_W-1:DATA_W-1]) & (|full[FULL_W-1:DATA_W-1]);
    wr_val = ovf ? {full[FULL_W-1], {(DATA_W-1){~full[FULL_W-1]}}} : full[DATA_W-1:0];
    sat_d = sat_q | (s1_valid_q & ovf);
  end
  always_comb begin
    hs = out_valid_q & bus.out_ready;
    last = cnt_q == (ADDR_W+1)'(1);
    ptr_nx = (ptr_q == ADDR_W'(DEPTH-1)) ? '0 : ptr_q + ADDR_W'(1);
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    out_data_d = out_data_q;
    mem_d = mem_q;
    if (s1_valid_q) mem_d[s1_addr_q] = wr_val;
    if (hs) mem_d[ptr_q] = '0;
    if (state_q == IDLE && bus.drain_start && bus.drain_len != '0) begin
      state_d = FLUSH;
      ptr_d = bus.drain_base;
      cnt_d = (bus.drain_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.drain_len;
    end else if (state_q == FLUSH) begin
      state_d = DRAIN;
      out_data_d = mem_q[ptr_q];
    end else if (state_q == DRAIN && hs) begin
      state_d = last ? IDLE : DRAIN;
      ptr_d = ptr_nx;
      cnt_d = cnt_q - (ADDR_W+1)'(1);
      out_data_d = last ? out_data_q : mem_q[ptr_nx];
    end
    out_valid_d = (state_q == FLUSH) | (out_valid_q & ~(hs & last));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mem_q <= '{default: '0};
      s1_valid_q <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_addr_q <= '0;
      s1_sum_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q <= mem_d;
      s1_valid_q <= s1_valid_d;
      s1_mode_q <= s1_mode_d;
      s1_addr_q <= s1_addr_d;
      s1_sum_q <= s1_sum_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      sat_q <= sat_d;
    end
  end
  assign bus.in_ready = (state_q == IDLE) & ~bus.drain_start;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_addr = ptr_q;
  assign bus.busy = state_q != IDLE;
  assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: directed beats and drains, with drained beats checked against a scoreboard queue
module tb_accumulator_bank;
  localparam int A = 4;
  localparam int W = 32;
  localparam int D = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [AW+W-1:0] sb [$];
  logic [AW+W-1:0] exp_beat;
  always #5 clk = ~clk;
  accumulator_bank_if #(.ARR_SIZE(A), .DATA_W(W), .DEPTH(D)) bus ();
  accumulator_bank #(.ARR_SIZE(A), .DATA_W(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got addr %0d data %0h expected none", bus.out_addr, bus.out_data);
      end else begin
        exp_beat = sb.pop_front();
        check("out_addr", W'(bus.out_addr), W'(exp_beat[AW+W-1:W]));
        check("out_data", bus.out_data, exp_beat[W-1:0]);
      end
    end
  end
  task automatic push(input logic [AW-1:0] a, input logic [W-1:0] d);
    sb.push_back({a, d});
  endtask
  task automatic beat(input logic [AW-1:0] a, input logic m, input logic [W-1:0] l0, l1, l2, l3);
    bus.in_valid = 1'b1;
    bus.in_addr = a;
    bus.in_mode = m;
    bus.in_data = {l3, l2, l1, l0};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic start_drain(input logic [AW-1:0] base, input logic [AW:0] len);
    bus.drain_start = 1'b1;
    bus.drain_base = base;
    bus.drain_len = len;
    #1;
    check("in_ready_at_start", W'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    check("flush_valid", W'(bus.out_valid), 0);
    check("flush_busy", W'(bus.busy), 1);
    @(posedge clk);
    #1;
    check("first_valid", W'(bus.out_valid), 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout busy %0d expected 0", bus.busy);
    end
    check("valid_after_drain", W'(bus.out_valid), 0);
  endtask
  task automatic drain(input logic [AW-1:0] base, input logic [AW:0] len);
    start_drain(base, len);
    wait_idle();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_addr = '0;
    bus.in_mode = 1'b0;
    bus.drain_start = 1'b0;
    bus.drain_base = '0;
    bus.drain_len = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(bus.out_valid), 0);
    check("rst_busy", W'(bus.busy), 0);
    check("rst_sat", W'(bus.sat_flag), 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_addr", W'(bus.out_addr), 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", W'(bus.in_ready), 1);
    repeat (3) beat(3, 0, 1, 2, 3, 4);
    push(3, 30);
    drain(3, 1);
    push(3, 0);
    drain(3, 1);
    beat(5, 0, 10, 0, 0, 0);
    beat(5, 1, 3, 4, 0, 0);
    push(5, 7);
    drain(5, 1);
    check("no_sat_yet", W'(bus.sat_flag), 0);
    beat(9, 1, 32'h7FFF_FFF6, 0, 0, 0);
    beat(9, 0, 25, 25, 25, 25);
    beat(10, 1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    push(9, 32'h7FFF_FFFF);
    push(10, 32'h8000_0000);
    drain(9, 2);
    check("sat_set", W'(bus.sat_flag), 1);
    beat(14, 0, 1, 0, 0, 0);
    beat(15, 0, 0, 2, 0, 0);
    beat(0, 0, 0, 0, 3, 0);
    beat(1, 0, 0, 0, 0, 4);
    push(14, 1);
    push(15, 2);
    push(0, 3);
    push(1, 4);
    drain(14, 4);
    beat(6, 0, 11, 0, 0, 0);
    beat(7, 0, 22, 0, 0, 0);
    beat(8, 0, 33, 0, 0, 0);
    push(6, 11);
    push(7, 22);
    push(8, 33);
    bus.out_ready = 1'b0;
    start_drain(6, 3);
    check("bp_first_addr", W'(bus.out_addr), 6);
    check("bp_first_data", bus.out_data, 11);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (5) begin
      check("bp_hold_addr", W'(bus.out_addr), 7);
      check("bp_hold_data", bus.out_data, 22);
      check("bp_hold_valid", W'(bus.out_valid), 1);
      check("bp_in_ready", W'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_idle();
    check("sat_sticky", W'(bus.sat_flag), 1);
    beat(2, 0, 5, 0, 0, 0);
    beat(3, 0, 6, 0, 0, 0);
    beat(4, 0, 7, 0, 0, 0);
    push(2, 5);
    push(3, 6);
    start_drain(2, 3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_addr", W'(bus.out_addr), 4);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", W'(bus.out_valid), 0);
    check("mid_rst_busy", W'(bus.busy), 0);
    check("mid_rst_sat", W'(bus.sat_flag), 0);
    check("mid_rst_data", bus.out_data, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(AW'((5 + i) % 16), 0);
    drain(5, 20);
    bus.drain_start = 1'b1;
    bus.drain_len = '0;
    @(posedge clk);
    #1;
    bus.drain_start = 1'b0;
    check("len0_busy", W'(bus.busy), 0);
    check("len0_valid", W'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("len0_busy_later", W'(bus.busy), 0);
    check("sb_empty", W'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
